icache_dm: RTL and testbench

Parametrised direct-mapped instruction cache with an integrated miss-handling state machine. It sits between the fetch stage and the instruction memory. Fetch reads are served combinationally on a hit. A miss raises a stall to fetch, issues one line-refill request to memory, and installs the returned line. Beyond the fixed 4-line predecessor, it adds:
- configurable geometry
- a registered request/refill handshake
- a whole-cache flush
- a saturating miss counter

---
 rtl/icache_dm.sv | 118 +++++++++++
 tb/tb_icache_dm.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with a single-outstanding-miss refill FSM.
// Hits are served combinationally; misses stall fetch until the line returns.
module icache_dm #(
  parameter int ADDR_W = 20,
  parameter int WORD_W = 32,
  parameter int LINE_W = 128,
  parameter int LINES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              read_rqst_i,
  input  logic              flush_i,
  input  logic              mem_data_ready_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  output logic [WORD_W-1:0] data_o,
  output logic              hit_o,
  output logic              miss_o,
  output logic              rqst_to_mem_o,
  output logic [ADDR_W-1:0] addr_to_mem_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int BOFF_W = $clog2(WORD_W / 8);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   data_q [LINES];
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [LINES-1:0]    valid_q, valid_d;
  logic                rqst_q, rqst_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [IDX_W-1:0]    idx, widx;
  logic [TAG_W-1:0]    tag, wtag;
  logic [OFF_W-1:0]    wsel;
  logic [LINE_W-1:0]   rd_line;
  logic [ADDR_W-1:0]   req_line, rsp_line;
  logic                match, accept;

  assign idx      = addr_i[OFF_W +: IDX_W];
  assign tag      = addr_i[ADDR_W-1 -: TAG_W];
  assign wsel     = addr_i[OFF_W-1:0] >> BOFF_W;
  assign widx     = maddr_q[OFF_W +: IDX_W];
  assign wtag     = maddr_q[ADDR_W-1 -: TAG_W];
  assign req_line = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign rsp_line = {mem_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign rd_line = data_q[idx];
  assign match   = valid_q[idx] && (tag_q[idx] == tag);
  assign accept  = (state_q == WAIT) && mem_data_ready_i
                   && (rsp_line == maddr_q);

  assign hit_o         = read_rqst_i && match && (state_q == IDLE);
  assign miss_o        = read_rqst_i && !hit_o;
  assign data_o        = rd_line[wsel*WORD_W +: WORD_W];
  assign rqst_to_mem_o = rqst_q;
  assign addr_to_mem_o = maddr_q;
  assign miss_cnt_o    = cnt_q;

  always_comb begin
    state_d = state_q;
    rqst_d  = rqst_q;
    maddr_d = maddr_q;
    cnt_d   = cnt_q;
    // Flush first so a refill on the same edge leaves its line valid.
    valid_d = flush_i ? '0 : valid_q;
    unique case (state_q)
      IDLE: begin
        if (read_rqst_i && !match) begin
          maddr_d = req_line;
          rqst_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (accept) begin
          valid_d[widx] = 1'b1;
          rqst_d        = 1'b0;
          state_d       = IDLE;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rqst_q  <= 1'b0;
      maddr_q <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      rqst_q  <= rqst_d;
      maddr_q <= maddr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      data_q[widx] <= mem_data_i;
      tag_q[widx]  <= wtag;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: stimulus pushes expected hit words into a
// queue and a negedge monitor pops one for every cycle the cache hits.
module tb_icache_dm;

  logic         clk = 1'b0;
  logic         rst;
  logic [19:0]  addr;
  logic         rd;
  logic         flush;
  logic         mem_rdy;
  logic [127:0] mem_data;
  logic [19:0]  mem_addr;
  logic [31:0]  data_o;
  logic         hit_o;
  logic         miss_o;
  logic         rqst_o;
  logic [19:0]  maddr_o;
  logic [1:0]   cnt_o;

  int vecs = 0;
  int errs = 0;
  logic [31:0] expq [$];

  localparam logic [127:0] L1 = 128'h44443333_22221111_DDDDCCCC_BBBBAAAA;
  localparam logic [127:0] L2 = 128'h55556666_77778888_9999AAAA_BBBBCCCC;
  localparam logic [127:0] L3 = 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C;
  localparam logic [127:0] L4 = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;

  icache_dm #(.CNT_W(2)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .addr_i(addr),
    .read_rqst_i(rd),
    .flush_i(flush),
    .mem_data_ready_i(mem_rdy),
    .mem_data_i(mem_data),
    .mem_addr_i(mem_addr),
    .data_o(data_o),
    .hit_o(hit_o),
    .miss_o(miss_o),
    .rqst_to_mem_o(rqst_o),
    .addr_to_mem_o(maddr_o),
    .miss_cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (hit_o === 1'b1) begin
      if (expq.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_hit: addr %h data %h", addr, data_o);
      end else begin
        chk("hit_data", data_o, expq.pop_front());
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hit(input logic [19:0] a, input logic [31:0] w);
    rd = 1'b1;
    addr = a;
    expq.push_back(w);
    @(negedge clk);
    chk("hit_miss_o", 32'(miss_o), 32'd0);
    next();
    rd = 1'b0;
  endtask

  task automatic miss_refill(input logic [19:0] a, input logic [127:0] line,
                             input logic [31:0] w, input logic [1:0] cnt,
                             input int junk, input bit fl_acc);
    rd = 1'b1;
    addr = a;
    @(negedge clk);
    chk("miss_o_N", 32'(miss_o), 32'd1);
    chk("rqst_N", 32'(rqst_o), 32'd0);
    next();
    for (int j = 0; j < junk; j++) begin
      mem_rdy = 1'b1;
      mem_addr = 20'h00200;
      mem_data = ~line;
      @(negedge clk);
      chk("junk_rqst", 32'(rqst_o), 32'd1);
      chk("junk_miss_o", 32'(miss_o), 32'd1);
      next();
    end
    mem_rdy = 1'b1;
    mem_addr = a;
    mem_data = line;
    flush = fl_acc;
    @(negedge clk);
    chk("wait_rqst", 32'(rqst_o), 32'd1);
    chk("wait_addr", 32'(maddr_o), 32'(a & 20'hFFFF0));
    chk("wait_miss_o", 32'(miss_o), 32'd1);
    next();
    mem_rdy = 1'b0;
    flush = 1'b0;
    expq.push_back(w);
    @(negedge clk);
    chk("post_miss_o", 32'(miss_o), 32'd0);
    chk("post_rqst", 32'(rqst_o), 32'd0);
    chk("miss_cnt", 32'(cnt_o), 32'(cnt));
    next();
    rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd = 1'b1;
    addr = '0;
    flush = 1'b0;
    mem_rdy = 1'b0;
    mem_data = '0;
    mem_addr = '0;
    @(negedge clk);
    chk("rst_hit", 32'(hit_o), 32'd0);
    chk("rst_miss", 32'(miss_o), 32'd1);
    chk("rst_rqst", 32'(rqst_o), 32'd0);
    chk("rst_addr", 32'(maddr_o), 32'd0);
    chk("rst_cnt", 32'(cnt_o), 32'd0);
    next();
    rst = 1'b0;
    rd = 1'b0;
    next();

    miss_refill(20'h00104, L1, 32'hDDDDCCCC, 2'd1, 0, 1'b0);
    read_hit(20'h00108, 32'h22221111);
    read_hit(20'h0010C, 32'h44443333);
    miss_refill(20'h00140, L2, 32'hBBBBCCCC, 2'd2, 0, 1'b0);
    miss_refill(20'h00104, L1, 32'hDDDDCCCC, 2'd3, 2, 1'b0);
    miss_refill(20'h00118, L3, 32'h1E1E1E1E, 2'd3, 0, 1'b0);
    read_hit(20'h00100, 32'hBBBBAAAA);

    flush = 1'b1;
    next();
    flush = 1'b0;
    mem_rdy = 1'b1;
    mem_addr = 20'h00100;
    mem_data = L1;
    next();
    mem_rdy = 1'b0;
    miss_refill(20'h00104, L1, 32'hDDDDCCCC, 2'd3, 0, 1'b1);
    read_hit(20'h00100, 32'hBBBBAAAA);
    miss_refill(20'h00118, L3, 32'h1E1E1E1E, 2'd3, 0, 1'b0);

    rd = 1'b1;
    addr = 20'h00124;
    @(negedge clk);
    chk("abort_miss_o", 32'(miss_o), 32'd1);
    next();
    @(negedge clk);
    chk("abort_rqst_pre", 32'(rqst_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_rqst", 32'(rqst_o), 32'd0);
    chk("abort_cnt", 32'(cnt_o), 32'd0);
    chk("abort_addr", 32'(maddr_o), 32'd0);
    rd = 1'b0;
    next();
    rst = 1'b0;
    mem_rdy = 1'b1;
    mem_addr = 20'h00120;
    mem_data = L4;
    next();
    mem_rdy = 1'b0;
    miss_refill(20'h00124, L4, 32'hC2C2C2C2, 2'd1, 0, 1'b0);
    miss_refill(20'h00134, L2, 32'h9999AAAA, 2'd2, 0, 1'b0);
    miss_refill(20'h00144, L1, 32'hDDDDCCCC, 2'd3, 0, 1'b0);
    miss_refill(20'h00154, L3, 32'h2D2D2D2D, 2'd3, 0, 1'b0);

    next();
    next();
    chk("pending_hits", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
